// File: rtl/core_run_timer_ctrl_if.sv
// Bus bundle for core_run_timer_ctrl: run control, per-core done levels,
// the readout port and the status outputs.
//   master: drives startN, clear, coreDone, rdSel (and coreMask when
//           CORE_MASK_EN is defined); observes everything else.
//   slave : the controller side of the same signals.
// Optional macro CORE_MASK_EN adds coreMask [NUM_CORES-1:0].
interface core_run_timer_ctrl_if #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned WIDTH     = 26
);
  localparam int unsigned SEL_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic                 startN;
  logic                 clear;
  logic [NUM_CORES-1:0] coreDone;
`ifdef CORE_MASK_EN
  logic [NUM_CORES-1:0] coreMask;
`endif
  logic [SEL_W-1:0]     rdSel;
  logic                 procStart;
  logic [WIDTH-1:0]     rdTime;
  logic                 rdValid;
  logic [WIDTH-1:0]     elapsed;
  logic [WIDTH-1:0]     totalTime;
  logic                 busy;
  logic                 allDone;
  logic                 timeout;

  modport master (
    output startN, clear, coreDone, rdSel,
`ifdef CORE_MASK_EN
    output coreMask,
`endif
    input  procStart, rdTime, rdValid, elapsed, totalTime, busy, allDone, timeout
  );

  modport slave (
    input  startN, clear, coreDone, rdSel,
`ifdef CORE_MASK_EN
    input  coreMask,
`endif
    output procStart, rdTime, rdValid, elapsed, totalTime, busy, allDone, timeout
  );
endinterface

// File: rtl/core_run_timer_ctrl.sv
// Run-timing controller: arms on active-low startN, pulses procStart for the
// first RUN cycle, counts cycles and snapshots the count when each required
// core first raises done. Ends in DONE (all required cores finished) or
// TIMEOUT (count reached TIMEOUT_CYCLES) and holds results until clear/reset.
// Ports:
//   clk  - system clock
//   rstN - asynchronous active-low reset
//   bus  - core_run_timer_ctrl_if.slave: startN, clear, coreDone, rdSel in;
//          procStart, rdTime, rdValid, elapsed, totalTime, busy, allDone,
//          timeout out. rdTime/rdValid are combinational readouts.
// Optional macro CORE_MASK_EN: adds bus.coreMask, latched at run start;
// only masked-in cores are captured and required for DONE.
module core_run_timer_ctrl #(
  parameter int unsigned NUM_CORES      = 4,
  parameter int unsigned WIDTH          = 26,
  parameter int unsigned TIMEOUT_CYCLES = 67108863
) (
  input logic                  clk,
  input logic                  rstN,
  core_run_timer_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_DONE    = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     counter_q, counter_d;
  logic [WIDTH-1:0]     total_q, total_d;
  logic [WIDTH-1:0]     cap_time_q [NUM_CORES];
  logic [NUM_CORES-1:0] captured_q, captured_d;
  logic [NUM_CORES-1:0] cap_load;
  logic                 cap_zero;
  logic                 proc_start_q, proc_start_d;
  logic [NUM_CORES-1:0] req;
  logic [NUM_CORES-1:0] cap_hit;
  logic [NUM_CORES-1:0] captured_set;
  logic                 all_req;
  logic [WIDTH-1:0]     rd_time;
  logic                 rd_valid;

`ifdef CORE_MASK_EN
  logic [NUM_CORES-1:0] mask_q, mask_d;
  assign req = mask_q;
`else
  assign req = '1;
`endif

  // Cores finishing this cycle, and whether that completes the required set
  assign cap_hit      = bus.coreDone & ~captured_q & req;
  assign captured_set = captured_q | cap_hit;
  assign all_req      = ((captured_set & req) == req);

  // State register
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state and datapath controls; clear overrides every transition
  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    total_d      = total_q;
    captured_d   = captured_q;
    cap_load     = '0;
    cap_zero     = 1'b0;
    proc_start_d = 1'b0;
`ifdef CORE_MASK_EN
    mask_d       = mask_q;
`endif
    if (bus.clear) begin
      state_d    = S_IDLE;
      counter_d  = '0;
      total_d    = '0;
      captured_d = '0;
      cap_zero   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          counter_d = '0;
          if (!bus.startN) begin
            state_d      = S_RUN;
            total_d      = '0;
            captured_d   = '0;
            cap_zero     = 1'b1;
            proc_start_d = 1'b1;
`ifdef CORE_MASK_EN
            mask_d       = bus.coreMask;
`endif
          end
        end
        S_RUN: begin
          cap_load   = cap_hit;
          captured_d = captured_set;
          // Completion beats timeout when both land on the same cycle
          if (all_req) begin
            state_d = S_DONE;
            total_d = counter_q;
          end else if (counter_q == WIDTH'(TIMEOUT_CYCLES)) begin
            state_d = S_TIMEOUT;
          end else begin
            counter_d = counter_q + WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Counter, results and start pulse registers
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      counter_q    <= '0;
      total_q      <= '0;
      captured_q   <= '0;
      proc_start_q <= 1'b0;
`ifdef CORE_MASK_EN
      mask_q       <= '0;
`endif
      for (int i = 0; i < int'(NUM_CORES); i++) cap_time_q[i] <= '0;
    end else begin
      counter_q    <= counter_d;
      total_q      <= total_d;
      captured_q   <= captured_d;
      proc_start_q <= proc_start_d;
`ifdef CORE_MASK_EN
      mask_q       <= mask_d;
`endif
      for (int i = 0; i < int'(NUM_CORES); i++) begin
        if (cap_zero)         cap_time_q[i] <= '0;
        else if (cap_load[i]) cap_time_q[i] <= counter_q;
      end
    end
  end

  // Combinational readout; out-of-range index reads as empty
  always_comb begin
    rd_time  = '0;
    rd_valid = 1'b0;
    if (32'(bus.rdSel) < NUM_CORES) begin
      rd_time  = cap_time_q[bus.rdSel];
      rd_valid = captured_q[bus.rdSel];
    end
  end

  assign bus.procStart = proc_start_q;
  assign bus.rdTime    = rd_time;
  assign bus.rdValid   = rd_valid;
  assign bus.elapsed   = counter_q;
  assign bus.totalTime = total_q;
  assign bus.busy      = (state_q == S_RUN);
  assign bus.allDone   = (state_q == S_DONE);
  assign bus.timeout   = (state_q == S_TIMEOUT);

endmodule

// File: tb/tb_core_run_timer_ctrl.sv
// Scoreboard bench for core_run_timer_ctrl (NUM_CORES=4, WIDTH=26,
// TIMEOUT_CYCLES=100). Stimulus pushes expected probes, run starts and run
// ends; a negedge monitor pops and compares when the DUT presents them.
module tb_core_run_timer_ctrl;
  localparam int unsigned NC   = 4;
  localparam int unsigned W    = 26;
  localparam int unsigned TO   = 100;
  localparam int unsigned PV_W = 5 + 3 * W;

  typedef logic [PV_W-1:0] pv_t;
  typedef struct { string tag; pv_t exp; } probe_t;
  typedef struct { string tag; logic done; logic [W-1:0] total; logic [W-1:0] el; } end_t;

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  logic probe = 1'b0;

  core_run_timer_ctrl_if #(.NUM_CORES(NC), .WIDTH(W)) bus ();

  core_run_timer_ctrl #(
    .NUM_CORES(NC), .WIDTH(W), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk (clk),
    .rstN(rstN),
    .bus (bus)
  );

  always #5 clk = ~clk;

  probe_t probe_q[$];
  end_t   end_q[$];
  int     start_q = 0;
  int     tests = 0;
  int     fails = 0;
  logic   prev_ps = 1'b0;
  logic   prev_end = 1'b0;
  probe_t pp;
  end_t   ee;
  pv_t    obs;

  function automatic pv_t mk(logic ps, logic b, logic d, logic t, logic v,
                             int rt, int el, int tt);
    return {ps, b, d, t, v, W'(rt), W'(el), W'(tt)};
  endfunction

  // Monitor: probes, procStart pulses and run-end events
  always @(negedge clk) begin
    obs = {bus.procStart, bus.busy, bus.allDone, bus.timeout, bus.rdValid,
           bus.rdTime, bus.elapsed, bus.totalTime};
    if (probe) begin
      tests++;
      if (probe_q.size() == 0) begin
        fails++;
        $display("FAIL probe_underflow got %h required none", obs);
      end else begin
        pp = probe_q.pop_front();
        if (obs !== pp.exp) begin
          fails++;
          $display("FAIL %s got %h required %h", pp.tag, obs, pp.exp);
        end
      end
    end
    if (rstN && bus.procStart) begin
      tests++;
      if (start_q == 0) begin
        fails++;
        $display("FAIL unexpected_procStart elapsed=%0d", bus.elapsed);
      end else begin
        start_q--;
        if (prev_ps || !bus.busy || bus.elapsed != '0) begin
          fails++;
          $display("FAIL procStart prev=%b busy=%b elapsed=%0d required 0/1/0",
                   prev_ps, bus.busy, bus.elapsed);
        end
      end
    end
    if (rstN && (bus.allDone || bus.timeout) && !prev_end) begin
      tests++;
      if (end_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_run_end done=%b to=%b", bus.allDone, bus.timeout);
      end else begin
        ee = end_q.pop_front();
        if ({bus.allDone, bus.timeout, bus.totalTime, bus.elapsed} !==
            {ee.done, ~ee.done, ee.total, ee.el}) begin
          fails++;
          $display("FAIL %s got done=%b to=%b total=%0d el=%0d required done=%b total=%0d el=%0d",
                   ee.tag, bus.allDone, bus.timeout, bus.totalTime, bus.elapsed,
                   ee.done, ee.total, ee.el);
        end
      end
    end
    prev_ps  = bus.procStart;
    prev_end = bus.allDone | bus.timeout;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, int sel, pv_t exp);
    bus.rdSel = 2'(sel);
    probe_q.push_back('{tag, exp});
    probe = 1'b1;
    @(negedge clk);
    #1 probe = 1'b0;
  endtask

  task automatic wait_count(int n);
    int g = 0;
    while (bus.elapsed != W'(n) && g < 400) begin
      tick();
      g++;
    end
    if (g >= 400) begin
      tests++;
      fails++;
      $display("FAIL wait_count got %0d required %0d", bus.elapsed, n);
    end
  endtask

  task automatic wait_end();
    int g = 0;
    while (!(bus.allDone || bus.timeout) && g < 400) begin
      tick();
      g++;
    end
    if (g >= 400) begin
      tests++;
      fails++;
      $display("FAIL wait_end got busy=%b required run end", bus.busy);
    end
  endtask

  task automatic start_pulse();
    start_q++;
    tick();
    bus.startN = 1'b0;
    tick();
    bus.startN = 1'b1;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear    = 1'b0;
    bus.coreDone = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bus.startN   = 1'b1;
    bus.clear    = 1'b0;
    bus.coreDone = '0;
    bus.rdSel    = '0;
`ifdef CORE_MASK_EN
    bus.coreMask = '1;
`endif
    #2;
    chk("reset_hold", 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    rstN = 1'b1;
    tick();
    chk("reset_idle", 1, mk(0, 0, 0, 0, 0, 0, 0, 0));

    // 1: normal run
    start_pulse();
    chk("t1_start", 0, mk(1, 1, 0, 0, 0, 0, 0, 0));
    wait_count(5);  bus.coreDone[2] = 1'b1;
    wait_count(9);  bus.coreDone[0] = 1'b1;
    wait_count(12);
    end_q.push_back('{"t1_end", 1'b1, W'(12), W'(12)});
    bus.coreDone[1] = 1'b1;
    bus.coreDone[3] = 1'b1;
    tick();
    chk("t1_rd0", 0, mk(0, 0, 1, 0, 1, 9, 12, 12));
    chk("t1_rd1", 1, mk(0, 0, 1, 0, 1, 12, 12, 12));
    chk("t1_rd2", 2, mk(0, 0, 1, 0, 1, 5, 12, 12));
    chk("t1_rd3", 3, mk(0, 0, 1, 0, 1, 12, 12, 12));
    do_clear();
    chk("t1_clear", 0, mk(0, 0, 0, 0, 0, 0, 0, 0));

    // 2: timeout with one core finished
    start_pulse();
    wait_count(3);
    bus.coreDone[0] = 1'b1;
    end_q.push_back('{"t2_end", 1'b0, W'(0), W'(100)});
    wait_end();
    chk("t2_rd0", 0, mk(0, 0, 0, 1, 1, 3, 100, 0));
    chk("t2_rd1", 1, mk(0, 0, 0, 1, 0, 0, 100, 0));
    do_clear();

    // 3: last core lands exactly on the timeout count
    start_pulse();
    wait_count(2);
    bus.coreDone = 4'b0111;
    wait_count(100);
    end_q.push_back('{"t3_end", 1'b1, W'(100), W'(100)});
    bus.coreDone[3] = 1'b1;
    tick();
    chk("t3_rd3", 3, mk(0, 0, 1, 0, 1, 100, 100, 100));
    chk("t3_rd0", 0, mk(0, 0, 1, 0, 1, 2, 100, 100));
    do_clear();

    // 4: done levels already high before start
    bus.coreDone = 4'b1111;
    end_q.push_back('{"t4_end", 1'b1, W'(0), W'(0)});
    start_pulse();
    tick();
    chk("t4_rd2", 2, mk(0, 0, 1, 0, 1, 0, 0, 0));
    do_clear();

    // 5: clear mid-run, async reset mid-run, clear with startN held low
    start_pulse();
    wait_count(20);
    do_clear();
    chk("t5_clear", 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
    start_pulse();
    wait_count(7);
    rstN = 1'b0;
    chk("t5_rst", 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    rstN = 1'b1;
    tick();
    start_q++;
    bus.startN = 1'b0;
    tick();
    wait_count(3);
    do_clear();
    chk("t5_clear_lvl", 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
    start_q++;
    tick();
    bus.startN = 1'b1;
    chk("t5_restart", 0, mk(1, 1, 0, 0, 0, 0, 0, 0));
    do_clear();

`ifdef CORE_MASK_EN
    // 6: only masked-in cores are required
    bus.coreMask = 4'b0101;
    start_pulse();
    wait_count(4);  bus.coreDone[0] = 1'b1;
    wait_count(8);
    end_q.push_back('{"t6_end", 1'b1, W'(8), W'(8)});
    bus.coreDone[2] = 1'b1;
    tick();
    chk("t6_rd1", 1, mk(0, 0, 1, 0, 0, 0, 8, 8));
    chk("t6_rd3", 3, mk(0, 0, 1, 0, 0, 0, 8, 8));
    chk("t6_rd2", 2, mk(0, 0, 1, 0, 1, 8, 8, 8));
    bus.coreMask = '1;
    do_clear();
`endif

    tick();
    tick();
    tests++;
    if (start_q != 0 || end_q.size() != 0 || probe_q.size() != 0) begin
      fails++;
      $display("FAIL leftover_expectations starts=%0d ends=%0d probes=%0d required 0",
               start_q, end_q.size(), probe_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
